// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the LEGv8-subset core.
// Steps FETCH/DECODE/EXEC/MEM/WB with req/ready memory handshakes.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        cond_true,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        flag_write,
  output logic        fault,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_ILL,
    C_B,
    C_CBZ,
    C_CBNZ,
    C_BCOND,
    C_MOVZ,
    C_IMM,
    C_RTYPE,
    C_SUBS,
    C_LDUR,
    C_STUR
  } cls_t;

  localparam bit TO_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_wait;
  logic             timeout_hit;

  logic [5:0]  op6;
  logic [7:0]  op8;
  logic [8:0]  op9;
  logic [9:0]  op10;
  logic [10:0] op11;
  logic        unused_bits;

  assign op6  = instruction[31:26];
  assign op8  = instruction[31:24];
  assign op9  = instruction[31:23];
  assign op10 = instruction[31:22];
  assign op11 = instruction[31:21];
  assign unused_bits = ^instruction[20:0];

  // Opcode fields are prefix-disjoint, so at most one arm matches.
  always_comb begin
    cls_d = C_ILL;
    unique case (1'b1)
      op6  == 6'b000101:       cls_d = C_B;
      op8  == 8'b10110100:     cls_d = C_CBZ;
      op8  == 8'b10110101:     cls_d = C_CBNZ;
      op8  == 8'b01010100:     cls_d = C_BCOND;
      op9  == 9'b110100101:    cls_d = C_MOVZ;
      op10 == 10'b1001000100:  cls_d = C_IMM;
      op10 == 10'b1101000100:  cls_d = C_IMM;
      op11 == 11'b10001011000: cls_d = C_RTYPE;
      op11 == 11'b11001011000: cls_d = C_RTYPE;
      op11 == 11'b10001010000: cls_d = C_RTYPE;
      op11 == 11'b10101010000: cls_d = C_RTYPE;
      op11 == 11'b11101011000: cls_d = C_SUBS;
      op11 == 11'b11111000010: cls_d = C_LDUR;
      op11 == 11'b11111000000: cls_d = C_STUR;
      default:                 cls_d = C_ILL;
    endcase
  end

  assign mem_wait =
    (state_q == S_FETCH && !imem_ready) ||
    (state_q == S_MEM   && !dmem_ready);

  assign timeout_hit = TO_EN && (cnt_q >= TO_LAST);

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd2;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    flag_write = 1'b0;
    // Outputs are forced idle while rst is held so a pending
    // request is withdrawn in the same cycle reset arrives.
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = 2'd0;
            state_d  = S_DECODE;
          end else if (timeout_hit) begin
            state_d = S_FAULT;
          end
        end
        S_DECODE: begin
          state_d = (cls_d == C_ILL) ? S_FAULT : S_EXEC;
        end
        S_EXEC: begin
          state_d = S_FETCH;
          unique case (cls_q)
            C_B: begin
              pc_write = 1'b1;
              pc_src   = 2'd1;
            end
            C_CBZ: begin
              alu_op = 2'b01;
              if (zero) begin
                pc_write = 1'b1;
                pc_src   = 2'd1;
              end
            end
            C_CBNZ: begin
              alu_op = 2'b01;
              if (!zero) begin
                pc_write = 1'b1;
                pc_src   = 2'd1;
              end
            end
            C_BCOND: begin
              alu_op = 2'b01;
              if (cond_true) begin
                pc_write = 1'b1;
                pc_src   = 2'd1;
              end
            end
            C_LDUR, C_STUR: begin
              alu_src = 1'b1;
              alu_op  = 2'b00;
              state_d = S_MEM;
            end
            C_RTYPE: begin
              alu_op  = 2'b10;
              state_d = S_WB;
            end
            C_SUBS: begin
              alu_op     = 2'b10;
              flag_write = 1'b1;
              state_d    = S_WB;
            end
            C_MOVZ, C_IMM: begin
              alu_src = 1'b1;
              alu_op  = 2'b11;
              state_d = S_WB;
            end
            default: state_d = S_FAULT;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == C_STUR);
          alu_src  = 1'b1;
          if (dmem_ready) begin
            state_d = (cls_q == C_STUR) ? S_FETCH : S_WB;
          end else if (timeout_hit) begin
            state_d = S_FAULT;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_q == C_LDUR);
          state_d    = S_FETCH;
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_FAULT;
      endcase
    end
  end

  // Saturating wait counter, cleared whenever the state changes.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (mem_wait && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_ILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_DECODE) begin
        cls_q <= cls_d;
      end
    end
  end

  assign fault = (state_q == S_FAULT);
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer.
// Two instances: default timeout and MEM_TIMEOUT=4.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        zero, cond_true;
  logic        imem_ready, dmem_ready;

  logic       imem_req, dmem_req, dmem_we;
  logic       ir_write, pc_write, alu_src;
  logic [1:0] pc_src, alu_op;
  logic       reg_write, mem_to_reg, flag_write;
  logic       fault;
  logic [2:0] state;

  logic       imem_req_t, dmem_req_t, dmem_we_t;
  logic       ir_write_t, pc_write_t, alu_src_t;
  logic [1:0] pc_src_t, alu_op_t;
  logic       reg_write_t, mem_to_reg_t, flag_write_t;
  logic       fault_t;
  logic [2:0] state_t;

  // {state, imem_req, dmem_req, dmem_we, ir_write, pc_write,
  //  pc_src, alu_src, alu_op, reg_write, mem_to_reg, flag_write}
  logic [15:0] v;
  assign v = {state, imem_req, dmem_req, dmem_we, ir_write,
              pc_write, pc_src, alu_src, alu_op, reg_write,
              mem_to_reg, flag_write};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_sequencer dut (
    .clk(clk), .rst(rst), .instruction(instruction),
    .zero(zero), .cond_true(cond_true),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src),
    .alu_src(alu_src), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .flag_write(flag_write), .fault(fault), .state(state)
  );

  multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_W(8)) dut_t (
    .clk(clk), .rst(rst), .instruction(instruction),
    .zero(zero), .cond_true(cond_true),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req_t), .dmem_req(dmem_req_t),
    .dmem_we(dmem_we_t), .ir_write(ir_write_t),
    .pc_write(pc_write_t), .pc_src(pc_src_t),
    .alu_src(alu_src_t), .alu_op(alu_op_t),
    .reg_write(reg_write_t), .mem_to_reg(mem_to_reg_t),
    .flag_write(flag_write_t), .fault(fault_t),
    .state(state_t)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    rst = 1'b1;
    #1;
    total++;
    if (v !== 16'b000_0_0_0_0_0_10_0_00_0_0_0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=%b",
               v, 16'b000_0_0_0_0_0_10_0_00_0_0_0);
    end
    total++;
    if (fault !== 1'b0 || fault_t !== 1'b0) begin
      bad++;
      $display("FAIL reset_fault got=%b%b want=00",
               fault, fault_t);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_add;
    int fw;
    fw = 0;
    do_reset();
    instruction = 32'h8B020020;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    #1;
    total++;
    if (v !== 16'b000_1_0_0_1_1_00_0_00_0_0_0) begin
      bad++;
      $display("FAIL add_c0 got=%b want=%b",
               v, 16'b000_1_0_0_1_1_00_0_00_0_0_0);
    end
    fw += int'(flag_write);
    tick();
    total++;
    if (v !== 16'b001_0_0_0_0_0_10_0_00_0_0_0) begin
      bad++;
      $display("FAIL add_c1 got=%b want=%b",
               v, 16'b001_0_0_0_0_0_10_0_00_0_0_0);
    end
    fw += int'(flag_write);
    tick();
    total++;
    if (v !== 16'b010_0_0_0_0_0_10_0_10_0_0_0) begin
      bad++;
      $display("FAIL add_c2 got=%b want=%b",
               v, 16'b010_0_0_0_0_0_10_0_10_0_0_0);
    end
    fw += int'(flag_write);
    tick();
    total++;
    if (v !== 16'b100_0_0_0_0_0_10_0_00_1_0_0) begin
      bad++;
      $display("FAIL add_c3 got=%b want=%b",
               v, 16'b100_0_0_0_0_0_10_0_00_1_0_0);
    end
    fw += int'(flag_write);
    tick();
    total++;
    if (v !== 16'b000_1_0_0_1_1_00_0_00_0_0_0) begin
      bad++;
      $display("FAIL add_c4 got=%b want=%b",
               v, 16'b000_1_0_0_1_1_00_0_00_0_0_0);
    end
    total++;
    if (fw !== 0) begin
      bad++;
      $display("FAIL add_flag_write got=%0d want=0", fw);
    end
  endtask

  task automatic test_ldur_wait;
    int req_n, rw_n;
    req_n = 0;
    rw_n  = 0;
    do_reset();
    instruction = 32'hF8408020;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    #1;
    tick();
    tick();
    total++;
    if (v !== 16'b010_0_0_0_0_0_10_1_00_0_0_0) begin
      bad++;
      $display("FAIL ldur_exec got=%b want=%b",
               v, 16'b010_0_0_0_0_0_10_1_00_0_0_0);
    end
    for (int k = 3; k <= 6; k++) begin
      tick();
      dmem_ready = (k == 6);
      #1;
      total++;
      if (v !== 16'b011_0_1_0_0_0_10_1_00_0_0_0) begin
        bad++;
        $display("FAIL ldur_mem_c%0d got=%b want=%b", k,
                 v, 16'b011_0_1_0_0_0_10_1_00_0_0_0);
      end
      req_n += int'(dmem_req);
      rw_n  += int'(reg_write);
    end
    total++;
    if (req_n !== 4) begin
      bad++;
      $display("FAIL ldur_req_cycles got=%0d want=4", req_n);
    end
    tick();
    dmem_ready = 1'b0;
    #1;
    total++;
    if (v !== 16'b100_0_0_0_0_0_10_0_00_1_1_0) begin
      bad++;
      $display("FAIL ldur_wb got=%b want=%b",
               v, 16'b100_0_0_0_0_0_10_0_00_1_1_0);
    end
    rw_n += int'(reg_write);
    tick();
    rw_n += int'(reg_write);
    total++;
    if (state !== 3'd0 || rw_n !== 1) begin
      bad++;
      $display("FAIL ldur_done got=state%0d/rw%0d want=0/1",
               state, rw_n);
    end
  endtask

  task automatic test_cbz;
    int rw_n;
    rw_n = 0;
    do_reset();
    instruction = 32'hB4000040;
    imem_ready = 1'b1;
    zero = 1'b1;
    #1;
    rw_n += int'(reg_write);
    tick();
    rw_n += int'(reg_write);
    tick();
    total++;
    if (v !== 16'b010_0_0_0_0_1_01_0_01_0_0_0) begin
      bad++;
      $display("FAIL cbz_taken got=%b want=%b",
               v, 16'b010_0_0_0_0_1_01_0_01_0_0_0);
    end
    rw_n += int'(reg_write);
    tick();
    zero = 1'b0;
    #1;
    total++;
    if (state !== 3'd0) begin
      bad++;
      $display("FAIL cbz_ret1 got=%0d want=0", state);
    end
    rw_n += int'(reg_write);
    tick();
    rw_n += int'(reg_write);
    tick();
    total++;
    if ({state, pc_write} !== 4'b010_0) begin
      bad++;
      $display("FAIL cbz_not_taken got=%b want=0100",
               {state, pc_write});
    end
    rw_n += int'(reg_write);
    tick();
    total++;
    if (state !== 3'd0 || rw_n !== 0) begin
      bad++;
      $display("FAIL cbz_ret2 got=state%0d/rw%0d want=0/0",
               state, rw_n);
    end
  endtask

  task automatic test_subs;
    int fw;
    fw = 0;
    do_reset();
    instruction = 32'hEB02003F;
    imem_ready = 1'b1;
    #1;
    fw += int'(flag_write);
    tick();
    fw += int'(flag_write);
    tick();
    total++;
    if (v !== 16'b010_0_0_0_0_0_10_0_10_0_0_1) begin
      bad++;
      $display("FAIL subs_exec got=%b want=%b",
               v, 16'b010_0_0_0_0_0_10_0_10_0_0_1);
    end
    fw += int'(flag_write);
    tick();
    fw += int'(flag_write);
    tick();
    fw += int'(flag_write);
    total++;
    if (fw !== 1) begin
      bad++;
      $display("FAIL subs_flag_cycles got=%0d want=1", fw);
    end
  endtask

  task automatic test_illegal;
    int viol;
    viol = 0;
    do_reset();
    instruction = 32'h00000000;
    imem_ready = 1'b1;
    #1;
    tick();
    tick();
    total++;
    if (v !== 16'b111_0_0_0_0_0_10_0_00_0_0_0 ||
        fault !== 1'b1) begin
      bad++;
      $display("FAIL illegal_fault got=%b/%b want=%b/1",
               v, fault, 16'b111_0_0_0_0_0_10_0_00_0_0_0);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (imem_req !== 1'b0 || fault !== 1'b1 ||
          state !== 3'd7) viol++;
    end
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL illegal_sticky got=%0d want=0", viol);
    end
    rst = 1'b1;
    #1;
    total++;
    if (state !== 3'd0 || fault !== 1'b0) begin
      bad++;
      $display("FAIL illegal_rst got=%0d/%b want=0/0",
               state, fault);
    end
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_timeout;
    int viol;
    int k;
    viol = 0;
    do_reset();
    instruction = 32'h8B020020;
    imem_ready = 1'b0;
    #1;
    for (k = 0; k < 4; k++) begin
      if (state_t !== 3'd0 || imem_req_t !== 1'b1 ||
          fault_t !== 1'b0) viol++;
      tick();
    end
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL timeout4_wait got=%0d want=0", viol);
    end
    total++;
    if (state_t !== 3'd7 || fault_t !== 1'b1 ||
        imem_req_t !== 1'b0) begin
      bad++;
      $display("FAIL timeout4_fault got=%0d/%b want=7/1",
               state_t, fault_t);
    end
    viol = 0;
    for (k = 4; k < 255; k++) begin
      if (state !== 3'd0 || fault !== 1'b0 ||
          imem_req !== 1'b1) viol++;
      tick();
    end
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL timeout255_early got=%0d want=0", viol);
    end
    total++;
    if (state !== 3'd7 || fault !== 1'b1) begin
      bad++;
      $display("FAIL timeout255_fault got=%0d/%b want=7/1",
               state, fault);
    end
    imem_ready = 1'b1;
  endtask

  task automatic test_rst_mid_mem;
    do_reset();
    instruction = 32'hF8408020;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    #1;
    tick();
    tick();
    tick();
    total++;
    if (state !== 3'd3 || dmem_req !== 1'b1) begin
      bad++;
      $display("FAIL rstmem_pre got=%0d/%b want=3/1",
               state, dmem_req);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (state !== 3'd0 || dmem_req !== 1'b0) begin
      bad++;
      $display("FAIL rstmem_drop got=%0d/%b want=0/0",
               state, dmem_req);
    end
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back;
    do_reset();
    instruction = 32'hF8000020;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    cond_true = 1'b0;
    #1;
    tick();
    tick();
    tick();
    total++;
    if (v !== 16'b011_0_1_1_0_0_10_1_00_0_0_0) begin
      bad++;
      $display("FAIL stur_mem got=%b want=%b",
               v, 16'b011_0_1_1_0_0_10_1_00_0_0_0);
    end
    tick();
    instruction = 32'h14000003;
    #1;
    total++;
    if (state !== 3'd0) begin
      bad++;
      $display("FAIL stur_latency got=%0d want=0", state);
    end
    tick();
    tick();
    total++;
    if (v !== 16'b010_0_0_0_0_1_01_0_00_0_0_0) begin
      bad++;
      $display("FAIL b_exec got=%b want=%b",
               v, 16'b010_0_0_0_0_1_01_0_00_0_0_0);
    end
    tick();
    instruction = 32'h54000040;
    #1;
    tick();
    tick();
    total++;
    if ({state, pc_write, reg_write} !== 5'b010_0_0) begin
      bad++;
      $display("FAIL bcond_not_taken got=%b want=01000",
               {state, pc_write, reg_write});
    end
    tick();
    instruction = 32'hD2800020;
    #1;
    tick();
    tick();
    total++;
    if (v !== 16'b010_0_0_0_0_0_10_1_11_0_0_0) begin
      bad++;
      $display("FAIL movz_exec got=%b want=%b",
               v, 16'b010_0_0_0_0_0_10_1_11_0_0_0);
    end
    tick();
    total++;
    if (v !== 16'b100_0_0_0_0_0_10_0_00_1_0_0) begin
      bad++;
      $display("FAIL movz_wb got=%b want=%b",
               v, 16'b100_0_0_0_0_0_10_0_00_1_0_0);
    end
    tick();
    instruction = 32'h91000420;
    #1;
    tick();
    tick();
    total++;
    if (v !== 16'b010_0_0_0_0_0_10_1_11_0_0_0) begin
      bad++;
      $display("FAIL addi_exec got=%b want=%b",
               v, 16'b010_0_0_0_0_0_10_1_11_0_0_0);
    end
  endtask

  initial begin
    rst = 1'b1;
    instruction = 32'h0;
    zero = 1'b0;
    cond_true = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    test_reset();
    test_add();
    test_ldur_wait();
    test_cbz();
    test_subs();
    test_illegal();
    test_timeout();
    test_rst_mid_mem();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
